// File: rtl/sram_avalon_pkg.sv
// Shared widths and FSM state encoding for the Avalon-MM to async SRAM responder.
package sram_avalon_pkg;
    localparam int SRAM_AW  = 18;
    localparam int SRAM_DW  = 16;
    localparam int SRAM_BEW = 2;
    localparam int WAIT_CW  = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WREC = 3'd2,
        RD   = 3'd3,
        RTA  = 3'd4
    } state_t;
endpackage

// File: rtl/sram_avalon_responder.sv
// Avalon-MM slave that sequences single-word reads/writes onto a 256K x 16 async SRAM.
// Handshake: a command is taken on any rising edge where avs_read or avs_write is high
// and avs_waitrequest is low; read data returns later as a one-cycle avs_readdatavalid.
module sram_avalon_responder
    import sram_avalon_pkg::*;
#(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SRAM_AW-1:0]  avs_address,
    input  logic [SRAM_BEW-1:0] avs_byteenable,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [SRAM_DW-1:0]  avs_writedata,
    output logic [SRAM_DW-1:0]  avs_readdata,
    output logic                avs_waitrequest,
    output logic                avs_readdatavalid,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic                SRAM_CE_N,
    output logic                SRAM_OE_N,
    output logic                SRAM_WE_N,
    output logic                SRAM_UB_N,
    output logic                SRAM_LB_N
);
    localparam logic [WAIT_CW-1:0] RD_LOAD = WAIT_CW'(RD_WAIT - 1);
    localparam logic [WAIT_CW-1:0] WR_LOAD = WAIT_CW'(WR_WAIT - 1);

    state_t               state, state_next;
    logic [WAIT_CW-1:0]   wait_cnt, wait_cnt_next;
    logic [SRAM_DW-1:0]   wr_data;
    logic [SRAM_BEW-1:0]  wr_be, be_next;
    logic                 accept_wr, accept_rd;
    logic                 dq_oe, dq_oe_next;
    logic                 ce_n_next, oe_n_next, we_n_next, ub_n_next, lb_n_next;

    assign SRAM_DQ           = dq_oe ? wr_data : {SRAM_DW{1'bz}};
    assign avs_waitrequest   = reset | (state != IDLE);
    assign avs_readdatavalid = (state == RTA);

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept_wr     = 1'b0;
        accept_rd     = 1'b0;
        case (state)
            IDLE: begin
                // A simultaneous read is dropped: the write wins.
                if (avs_write) begin
                    accept_wr     = 1'b1;
                    state_next    = WR;
                    wait_cnt_next = WR_LOAD;
                end else if (avs_read) begin
                    accept_rd     = 1'b1;
                    state_next    = RD;
                    wait_cnt_next = RD_LOAD;
                end
            end
            WR: begin
                if (wait_cnt == '0) state_next = WREC;
                else                wait_cnt_next = wait_cnt - WAIT_CW'(1);
            end
            WREC: state_next = IDLE;
            RD: begin
                if (wait_cnt == '0) state_next = RTA;
                else                wait_cnt_next = wait_cnt - WAIT_CW'(1);
            end
            RTA:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pins are registered, so decode them from the state being entered.
    always_comb begin
        be_next    = accept_wr ? avs_byteenable : wr_be;
        ce_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        we_n_next  = 1'b1;
        ub_n_next  = 1'b1;
        lb_n_next  = 1'b1;
        dq_oe_next = 1'b0;
        case (state_next)
            WR: begin
                ce_n_next  = 1'b0;
                we_n_next  = (be_next == '0);
                ub_n_next  = ~be_next[1];
                lb_n_next  = ~be_next[0];
                dq_oe_next = 1'b1;
            end
            WREC: begin
                ce_n_next  = 1'b0;
                ub_n_next  = ~be_next[1];
                lb_n_next  = ~be_next[0];
                dq_oe_next = 1'b1;
            end
            RD: begin
                ce_n_next = 1'b0;
                oe_n_next = 1'b0;
                ub_n_next = 1'b0;
                lb_n_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            wr_data      <= '0;
            wr_be        <= '0;
            SRAM_ADDR    <= '0;
            avs_readdata <= '0;
            dq_oe        <= 1'b0;
            SRAM_CE_N    <= 1'b1;
            SRAM_OE_N    <= 1'b1;
            SRAM_WE_N    <= 1'b1;
            SRAM_UB_N    <= 1'b1;
            SRAM_LB_N    <= 1'b1;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (accept_wr) begin
                wr_data <= avs_writedata;
                wr_be   <= avs_byteenable;
            end
            if (accept_wr || accept_rd) SRAM_ADDR <= avs_address;
            if (state == RD && wait_cnt == '0) avs_readdata <= SRAM_DQ;
            dq_oe     <= dq_oe_next;
            SRAM_CE_N <= ce_n_next;
            SRAM_OE_N <= oe_n_next;
            SRAM_WE_N <= we_n_next;
            SRAM_UB_N <= ub_n_next;
            SRAM_LB_N <= lb_n_next;
        end
    end
endmodule

// File: tb/tb_sram_avalon_responder.sv
// Bench for sram_avalon_responder: default-timing instance with an SRAM model plus a
// slow-timing instance, checked against a sparse memory reference and timing rules.
`timescale 1ns/1ps
module tb_sram_avalon_responder;
    localparam int A_RD = 1, A_WR = 1, B_RD = 3, B_WR = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- instance A (default waits) ----------------
    logic [17:0] a_address = '0;
    logic [1:0]  a_be = '0;
    logic        a_read = 1'b0, a_write = 1'b0;
    logic [15:0] a_wdata = '0;
    logic [15:0] a_rdata;
    logic        a_wait, a_rdv;
    logic [17:0] a_sram_addr;
    wire  [15:0] a_dq;
    logic        a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n;

    sram_avalon_responder dut_a (
        .clk(clk), .reset(reset),
        .avs_address(a_address), .avs_byteenable(a_be),
        .avs_read(a_read), .avs_write(a_write), .avs_writedata(a_wdata),
        .avs_readdata(a_rdata), .avs_waitrequest(a_wait), .avs_readdatavalid(a_rdv),
        .SRAM_ADDR(a_sram_addr), .SRAM_DQ(a_dq),
        .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n), .SRAM_WE_N(a_we_n),
        .SRAM_UB_N(a_ub_n), .SRAM_LB_N(a_lb_n)
    );

    // Async SRAM model for A, plus a bench driver used to prove the bus is released.
    logic [15:0] sram_mem [0:262143];
    logic        tb_drv_en = 1'b0;
    logic [15:0] tb_drv_val = '0;
    assign a_dq = (!a_ce_n && !a_oe_n && a_we_n) ? sram_mem[a_sram_addr] : 16'hzzzz;
    assign a_dq = tb_drv_en ? tb_drv_val : 16'hzzzz;
    always @(posedge a_we_n) begin
        if (a_ce_n == 1'b0) begin
            if (a_ub_n == 1'b0) sram_mem[a_sram_addr][15:8] = a_dq[15:8];
            if (a_lb_n == 1'b0) sram_mem[a_sram_addr][7:0]  = a_dq[7:0];
        end
    end

    // ---------------- instance B (RD_WAIT=3, WR_WAIT=2) ----------------
    logic [17:0] b_address = '0;
    logic        b_read = 1'b0, b_write = 1'b0;
    logic [15:0] b_wdata = '0;
    logic [15:0] b_rdata;
    logic        b_wait, b_rdv;
    logic [17:0] b_sram_addr;
    wire  [15:0] b_dq;
    logic        b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n;

    sram_avalon_responder #(.RD_WAIT(B_RD), .WR_WAIT(B_WR)) dut_b (
        .clk(clk), .reset(reset),
        .avs_address(b_address), .avs_byteenable(2'b11),
        .avs_read(b_read), .avs_write(b_write), .avs_writedata(b_wdata),
        .avs_readdata(b_rdata), .avs_waitrequest(b_wait), .avs_readdatavalid(b_rdv),
        .SRAM_ADDR(b_sram_addr), .SRAM_DQ(b_dq),
        .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n), .SRAM_WE_N(b_we_n),
        .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n)
    );
    assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? ~b_sram_addr[15:0] : 16'hzzzz;

    // ---------------- reference model ----------------
    logic [15:0] ref_mem [int];
    logic [15:0] exp_q [$];

    function automatic logic [15:0] init_val(input logic [17:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_read(input logic [17:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic void ref_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] v;
        v = ref_read(a);
        if (be[1]) v[15:8] = d[15:8];
        if (be[0]) v[7:0]  = d[7:0];
        ref_mem[int'(a)] = v;
    endfunction

    // ---------------- driver tasks ----------------
    // One command on A; observations are counted from the first cycle after the accept edge.
    task automatic do_cmd(input logic rd, input logic wr, input logic [17:0] a,
                          input logic [15:0] d, input logic [1:0] be,
                          output int wt, output int we_c, output int oe_c,
                          output int rdv_c, output int rdv_k, output logic [15:0] rdata,
                          output logic [15:0] dq_we, output logic [15:0] dq_hold,
                          output logic [1:0] lanes_n, output bit addr_bad, output bit to);
        int n;
        wt = 0; we_c = 0; oe_c = 0; rdv_c = 0; rdv_k = 0; rdata = '0;
        dq_we = '0; dq_hold = '0; lanes_n = 2'b11; addr_bad = 0; to = 0;
        @(negedge clk);
        a_read = rd; a_write = wr; a_address = a; a_wdata = d; a_be = be;
        n = 0;
        while (a_wait && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (a_wait) begin
            to = 1; a_read = 1'b0; a_write = 1'b0;
            return;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin a_read = 1'b0; a_write = 1'b0; end
            if (!a_we_n) begin we_c++; dq_we = a_dq; lanes_n = {a_ub_n, a_lb_n}; end
            if (!a_oe_n) oe_c++;
            if (!a_ce_n && a_we_n && a_oe_n) dq_hold = a_dq;
            if (!a_ce_n && a_sram_addr !== a) addr_bad = 1;
            if (a_rdv) begin rdv_c++; rdv_k = k; rdata = a_rdata; end
            if (!a_wait) return;
            wt++;
            if (k == 40) to = 1;
        end
    endtask

    task automatic do_cmd_b(input logic rd, input logic [17:0] a,
                            output int wt, output int we_c, output int oe_c,
                            output int rdv_k, output logic [15:0] rdata, output bit to);
        wt = 0; we_c = 0; oe_c = 0; rdv_k = 0; rdata = '0; to = 0;
        @(negedge clk);
        b_read = rd; b_write = !rd; b_address = a; b_wdata = 16'($urandom);
        if (b_wait) begin to = 1; b_read = 1'b0; b_write = 1'b0; return; end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin b_read = 1'b0; b_write = 1'b0; end
            if (!b_we_n) we_c++;
            if (!b_oe_n) oe_c++;
            if (b_rdv) begin rdv_k = k; rdata = b_rdata; end
            if (!b_wait) return;
            wt++;
            if (k == 40) to = 1;
        end
    endtask

    // ---------------- scenarios ----------------
    int wt, we_c, oe_c, rdv_c, rdv_k;
    logic [15:0] rdata, dq_we, dq_hold;
    logic [1:0]  lanes_n;
    bit addr_bad, to;

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if (a_wait !== 1'b1) $display("FAIL reset_wait: got %b expected 1", a_wait); else n_pass++;
        n_checks++; if (a_rdv !== 1'b0 || a_rdata !== 16'h0) $display("FAIL reset_rd: got rdv=%b data=%h expected 0/0000", a_rdv, a_rdata); else n_pass++;
        n_checks++; if ({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n} !== 5'b11111 || a_sram_addr !== 18'h0)
            $display("FAIL reset_pins: got strobes=%b addr=%h expected 11111/00000", {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n}, a_sram_addr); else n_pass++;
        n_checks++; if ({b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n, b_wait} !== 6'b111111)
            $display("FAIL reset_b: got %b expected 111111", {b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n, b_wait}); else n_pass++;
        tb_drv_en = 1'b1; tb_drv_val = 16'h5A3C; #1;
        n_checks++; if (a_dq !== 16'h5A3C) $display("FAIL reset_dq_release: got %h expected 5a3c", a_dq); else n_pass++;
        tb_drv_en = 1'b0;
        reset = 1'b0; #1;
        n_checks++; if (a_wait !== 1'b0) $display("FAIL idle_wait: got %b expected 0", a_wait); else n_pass++;
    endtask

    task automatic test_write;
        do_cmd(1'b0, 1'b1, 18'h00012, 16'hA5C3, 2'b11, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        ref_write(18'h00012, 16'hA5C3, 2'b11);
        n_checks++; if (to || wt != A_WR + 1) $display("FAIL write_wait: got %0d (to=%0d) expected %0d", wt, to, A_WR + 1); else n_pass++;
        n_checks++; if (we_c != A_WR || lanes_n !== 2'b00) $display("FAIL write_strobes: got we=%0d lanes=%b expected %0d/00", we_c, lanes_n, A_WR); else n_pass++;
        n_checks++; if (dq_we !== 16'hA5C3 || dq_hold !== 16'hA5C3) $display("FAIL write_dq: got wr=%h hold=%h expected a5c3", dq_we, dq_hold); else n_pass++;
        n_checks++; if (addr_bad || rdv_c != 0 || oe_c != 0) $display("FAIL write_misc: got addr_bad=%0d rdv=%0d oe=%0d expected 0", addr_bad, rdv_c, oe_c); else n_pass++;
    endtask

    task automatic test_readback;
        do_cmd(1'b1, 1'b0, 18'h00012, 16'h0, 2'b00, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        n_checks++; if (to || rdv_c != 1 || rdv_k != A_RD + 1) $display("FAIL read_valid: got count=%0d cycle=%0d expected 1/%0d", rdv_c, rdv_k, A_RD + 1); else n_pass++;
        n_checks++; if (rdata !== ref_read(18'h00012)) $display("FAIL read_data: got %h expected %h", rdata, ref_read(18'h00012)); else n_pass++;
        n_checks++; if (oe_c != A_RD || we_c != 0 || wt != A_RD + 1) $display("FAIL read_timing: got oe=%0d we=%0d wait=%0d expected %0d/0/%0d", oe_c, we_c, wt, A_RD, A_RD + 1); else n_pass++;
    endtask

    task automatic test_byte_write;
        do_cmd(1'b0, 1'b1, 18'h3FFFF, 16'hFFFF, 2'b11, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        ref_write(18'h3FFFF, 16'hFFFF, 2'b11);
        do_cmd(1'b0, 1'b1, 18'h3FFFF, 16'h1234, 2'b01, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        ref_write(18'h3FFFF, 16'h1234, 2'b01);
        n_checks++; if (lanes_n !== 2'b10 || we_c != 1) $display("FAIL byte_lanes: got lanes=%b we=%0d expected 10/1", lanes_n, we_c); else n_pass++;
        do_cmd(1'b1, 1'b0, 18'h3FFFF, 16'h0, 2'b00, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        n_checks++; if (rdv_c != 1 || rdata !== ref_read(18'h3FFFF)) $display("FAIL byte_readback: got %h expected %h", rdata, ref_read(18'h3FFFF)); else n_pass++;
        do_cmd(1'b0, 1'b1, 18'h3FFFF, 16'hABCD, 2'b00, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        n_checks++; if (we_c != 0 || wt != A_WR + 1) $display("FAIL be00_write: got we=%0d wait=%0d expected 0/%0d", we_c, wt, A_WR + 1); else n_pass++;
        do_cmd(1'b1, 1'b0, 18'h3FFFF, 16'h0, 2'b00, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        n_checks++; if (rdata !== ref_read(18'h3FFFF)) $display("FAIL be00_readback: got %h expected %h", rdata, ref_read(18'h3FFFF)); else n_pass++;
    endtask

    task automatic test_wait_params;
        do_cmd_b(1'b0, 18'h00040, wt, we_c, oe_c, rdv_k, rdata, to);
        n_checks++; if (to || we_c != B_WR || wt != B_WR + 1) $display("FAIL b_write: got we=%0d wait=%0d expected %0d/%0d", we_c, wt, B_WR, B_WR + 1); else n_pass++;
        do_cmd_b(1'b1, 18'h01234, wt, we_c, oe_c, rdv_k, rdata, to);
        n_checks++; if (to || oe_c != B_RD || wt != B_RD + 1) $display("FAIL b_read_timing: got oe=%0d wait=%0d expected %0d/%0d", oe_c, wt, B_RD, B_RD + 1); else n_pass++;
        n_checks++; if (rdv_k != B_RD + 1 || rdata !== 16'hEDCB) $display("FAIL b_read_data: got cycle=%0d data=%h expected %0d/edcb", rdv_k, rdata, B_RD + 1); else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [15:0] d;
        d = 16'($urandom);
        do_cmd(1'b1, 1'b1, 18'h00100, d, 2'b11, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        ref_write(18'h00100, d, 2'b11);
        n_checks++; if (rdv_c != 0 || we_c != 1 || oe_c != 0) $display("FAIL simul_cmd: got rdv=%0d we=%0d oe=%0d expected 0/1/0", rdv_c, we_c, oe_c); else n_pass++;
        do_cmd(1'b1, 1'b0, 18'h00100, 16'h0, 2'b00, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
        n_checks++; if (rdata !== ref_read(18'h00100)) $display("FAIL simul_readback: got %h expected %h", rdata, ref_read(18'h00100)); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int n_acc, n_pulse, cyc;
        bit acc;
        logic [15:0] e;
        n_acc = 0; n_pulse = 0; cyc = 0;
        exp_q.delete();
        @(negedge clk);
        a_read = 1'b1; a_address = 18'h00012;
        while ((n_acc < 4 || exp_q.size() > 0) && cyc < 100) begin
            acc = a_read && !a_wait;
            if (acc) exp_q.push_back(ref_read(a_address));
            @(negedge clk);
            cyc++;
            if (a_rdv) begin
                n_pulse++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                n_checks++; if (a_rdata !== e) $display("FAIL b2b_data: got %h expected %h", a_rdata, e); else n_pass++;
            end
            if (acc) begin
                n_acc++;
                if (n_acc < 4) a_address = (n_acc == 2) ? 18'h3FFFF : 18'(n_acc * 18'h00100);
                else a_read = 1'b0;
            end
        end
        a_read = 1'b0;
        n_checks++; if (cyc >= 100 || n_pulse != 4) $display("FAIL b2b_count: got pulses=%0d cycles=%0d expected 4 pulses", n_pulse, cyc); else n_pass++;
    endtask

    task automatic test_random;
        logic [17:0] pool [0:4];
        logic [17:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        int bad_w, bad_r;
        pool[0] = 18'h00012; pool[1] = 18'h00100; pool[2] = 18'h3FFFF; pool[3] = 18'h00000; pool[4] = 18'h15555;
        bad_w = 0; bad_r = 0;
        for (int i = 0; i < 24; i++) begin
            a  = pool[$urandom_range(0, 4)];
            d  = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                do_cmd(1'b0, 1'b1, a, d, be, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
                ref_write(a, d, be);
                if (to || wt != A_WR + 1 || we_c != ((be != 2'b00) ? A_WR : 0) || dq_hold !== d || addr_bad ||
                    (be != 2'b00 && lanes_n !== ~be)) begin
                    bad_w++;
                    $display("FAIL rand_write: addr=%h be=%b got we=%0d wait=%0d lanes=%b hold=%h expected data %h", a, be, we_c, wt, lanes_n, dq_hold, d);
                end
            end else begin
                do_cmd(1'b1, 1'b0, a, 16'h0, 2'b00, wt, we_c, oe_c, rdv_c, rdv_k, rdata, dq_we, dq_hold, lanes_n, addr_bad, to);
                if (to || rdv_c != 1 || rdv_k != A_RD + 1 || rdata !== ref_read(a)) begin
                    bad_r++;
                    $display("FAIL rand_read: addr=%h got %h (count=%0d cycle=%0d) expected %h", a, rdata, rdv_c, rdv_k, ref_read(a));
                end
            end
        end
        n_checks++; if (bad_w != 0) $display("FAIL rand_writes: got %0d bad expected 0", bad_w); else n_pass++;
        n_checks++; if (bad_r != 0) $display("FAIL rand_reads: got %0d bad expected 0", bad_r); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int rdv_seen;
        rdv_seen = 0;
        @(negedge clk);
        a_read = 1'b1; a_address = 18'h00012;
        @(negedge clk);
        a_read = 1'b0;
        n_checks++; if (a_oe_n !== 1'b0) $display("FAIL mid_in_rd: got oe_n=%b expected 0", a_oe_n); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        if (a_rdv) rdv_seen++;
        n_checks++; if ({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n, a_wait} !== 6'b111111)
            $display("FAIL mid_rd_reset: got %b expected 111111", {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n, a_wait}); else n_pass++;
        @(negedge clk);
        if (a_rdv) rdv_seen++;
        reset = 1'b0;
        a_write = 1'b1; a_address = 18'h2AAAA; a_wdata = 16'hA5C3; a_be = 2'b11;
        #1;
        n_checks++; if (a_wait !== 1'b0) $display("FAIL mid_first_accept: got wait=%b expected 0", a_wait); else n_pass++;
        @(negedge clk);
        if (a_rdv) rdv_seen++;
        a_write = 1'b0;
        n_checks++; if (a_we_n !== 1'b0 || a_wait !== 1'b1) $display("FAIL mid_accepted: got we_n=%b wait=%b expected 0/1", a_we_n, a_wait); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        if (a_rdv) rdv_seen++;
        tb_drv_en = 1'b1; tb_drv_val = 16'h5A3C; #1;
        n_checks++; if (a_dq !== 16'h5A3C || a_we_n !== 1'b1 || a_ce_n !== 1'b1) $display("FAIL mid_wr_release: got dq=%h we_n=%b ce_n=%b expected 5a3c/1/1", a_dq, a_we_n, a_ce_n); else n_pass++;
        tb_drv_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        if (a_rdv) rdv_seen++;
        n_checks++; if (rdv_seen != 0) $display("FAIL mid_no_rdv: got %0d pulses expected 0", rdv_seen); else n_pass++;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = init_val(18'(i));
        test_reset();
        test_write();
        test_readback();
        test_byte_write();
        test_wait_params();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
